// File: rtl/i2c_amm_pkg.sv
// Shared types and helpers for the I2C CSR Avalon-MM initiator.
//   state_t   : initiator FSM states
//   cmd_t     : command payload registered onto the bus
//   rsp_t     : response FIFO entry (read data + timeout error flag)
//   credit_ok : admission check for a new command
package i2c_amm_pkg;

  localparam int unsigned PKG_DATA_W = 16;
  localparam int unsigned PKG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [PKG_DATA_W-1:0] data;
    logic                  err;
  } rsp_t;

  // Writes never need a response slot; a read needs an outstanding slot
  // and a guaranteed place in the response FIFO.
  function automatic logic credit_ok(input logic        is_write,
                                     input int unsigned outst,
                                     input int unsigned used,
                                     input int unsigned max_outst,
                                     input int unsigned depth);
    return is_write || ((outst < max_outst) && ((outst + used) < depth));
  endfunction

endpackage

// File: rtl/avalon_mm_if.sv
// Avalon-MM bus with pipelined reads.
//   master : drives address/read/write/writedata, samples
//            waitrequest/readdata/readdatavalid
//   slave  : the opposite direction
interface avalon_mm_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/i2c_amm_rsp_fifo.sv
// Synchronous response FIFO; output word and flags come straight from flops.
//   clk_i, rst_i : clock, synchronous active-high reset
//   i_push/i_data: write port (ignored when full unless popping)
//   i_pop        : consume head (ignored when empty)
//   o_full/o_empty/o_used : occupancy
//   o_data       : head entry, valid while !o_empty
module i2c_amm_rsp_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_used,
  output logic [WIDTH-1:0]             o_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop frees a slot in the same cycle, so push+pop works even when full.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage (no reset needed; occupancy qualifies the contents)
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_used  = r_count;
  assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/i2c_amm_master.sv
// Avalon-MM initiator for the I2C controller CSR block.
// Turns a valid/ready command stream into bus reads/writes; reads are
// pipelined (up to MAX_OUTST outstanding) and their data is returned in
// order through a response FIFO. Writes produce no response.
// Optional read timeout with sticky HALT: define I2C_AMM_TIMEOUT_EN.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   cmd_valid_i/ready_o   : command handshake (write, addr, wdata)
//   rsp_valid_o/ready_i   : response handshake (data, err)
//   busy_o                : FSM not idle or reads still outstanding
//   amm_if                : Avalon-MM master modport
module i2c_amm_master
  import i2c_amm_pkg::*;
#(
  parameter int unsigned DATA_W    = PKG_DATA_W,
  parameter int unsigned ADDR_W    = PKG_ADDR_W,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned RSP_DEPTH = 8
`ifdef I2C_AMM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  avalon_mm_if.master       amm_if
);

  localparam int unsigned OUT_W  = $clog2(MAX_OUTST + 1);
  localparam int unsigned USED_W = $clog2(RSP_DEPTH + 1);
`ifdef I2C_AMM_TIMEOUT_EN
  localparam int unsigned FIFO_W = $bits(rsp_t);
`else
  localparam int unsigned FIFO_W = DATA_W;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  cmd_t                r_cmd;
  cmd_t                w_cmd;
  logic                r_active;
  logic [OUT_W-1:0]    r_outst;
  logic                w_inflight;
  logic                w_credit;
  logic                w_cmd_ready;
  logic                w_accept;
  logic                w_tmo_hit;
  logic                w_inc;
  logic                w_dec;
  logic                w_push;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [USED_W-1:0]   w_fifo_used;
  logic [FIFO_W-1:0]   w_fifo_din;
  logic [FIFO_W-1:0]   w_fifo_dout;
`ifdef I2C_AMM_TIMEOUT_EN
  rsp_t                w_push_rsp;
  rsp_t                w_pop_rsp;
`endif

  // Incoming command payload
  always_comb begin
    w_cmd       = '0;
    w_cmd.write = cmd_write_i;
    w_cmd.addr  = PKG_ADDR_W'(cmd_addr_i);
    w_cmd.wdata = PKG_DATA_W'(cmd_wdata_i);
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ISSUE;
      ISSUE:   if (!amm_if.waitrequest && !w_accept) w_state_nxt = IDLE;
`ifdef I2C_AMM_TIMEOUT_EN
      HALT:    w_state_nxt = HALT;
`endif
      default: w_state_nxt = IDLE;
    endcase
`ifdef I2C_AMM_TIMEOUT_EN
    if (w_tmo_hit) w_state_nxt = HALT;
`endif
  end

  // FSM outputs: command admission. A read currently on the bus is counted
  // as outstanding so a back-to-back accept cannot exceed the credit.
  always_comb begin
    w_inflight  = r_active && !r_cmd.write;
    w_credit    = credit_ok(cmd_write_i, 32'(r_outst) + 32'(w_inflight),
                            32'(w_fifo_used), MAX_OUTST, RSP_DEPTH)
                  && (cmd_write_i || !w_fifo_full);
    w_cmd_ready = 1'b0;
    case (r_state)
      IDLE:    w_cmd_ready = w_credit;
      ISSUE:   w_cmd_ready = !amm_if.waitrequest && w_credit;
      default: w_cmd_ready = 1'b0;
    endcase
    if (rst_i || w_tmo_hit) w_cmd_ready = 1'b0;
    w_accept = cmd_valid_i && w_cmd_ready;
  end

  assign cmd_ready_o = w_cmd_ready;

  // Bus command register: loads on accept, held through waitrequest,
  // dropped when the transfer finishes with nothing queued behind it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_active <= 1'b0;
      r_cmd    <= '0;
    end else if (w_accept) begin
      r_active <= 1'b1;
      r_cmd    <= w_cmd;
    end else if (w_state_nxt != ISSUE) begin
      r_active <= 1'b0;
    end
  end

  assign amm_if.address   = ADDR_W'(r_cmd.addr);
  assign amm_if.writedata = DATA_W'(r_cmd.wdata);
  assign amm_if.read      = r_active && !r_cmd.write;
  assign amm_if.write     = r_active && r_cmd.write;

  // Outstanding accounting and response push; stray readdatavalid is dropped
  always_comb begin
    w_inc  = r_active && !r_cmd.write && !amm_if.waitrequest;
    w_dec  = amm_if.readdatavalid && (r_outst != '0);
    w_push = w_dec;
`ifdef I2C_AMM_TIMEOUT_EN
    w_push_rsp      = '0;
    w_push_rsp.data = PKG_DATA_W'(amm_if.readdata);
    // HALT retires one outstanding read per cycle as an error response
    if (r_state == HALT) begin
      w_dec           = (r_outst != '0);
      w_push          = w_dec;
      w_push_rsp.data = '0;
      w_push_rsp.err  = 1'b1;
    end
    w_fifo_din = w_push_rsp;
`else
    w_fifo_din = amm_if.readdata;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outst <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_outst <= r_outst + OUT_W'(1);
        2'b01:   r_outst <= r_outst - OUT_W'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

`ifdef I2C_AMM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;

  // Cycles since the last readdatavalid while reads are pending
  always_ff @(posedge clk_i) begin
    if (rst_i || (r_outst == '0) || amm_if.readdatavalid) begin
      r_tmo <= '0;
    end else if (r_tmo != TMO_W'(TIMEOUT_CYCLES)) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign w_tmo_hit = (r_state != HALT) && (r_tmo == TMO_W'(TIMEOUT_CYCLES));
`else
  assign w_tmo_hit = 1'b0;
`endif

  i2c_amm_rsp_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_fifo_din),
    .i_pop   (rsp_ready_i),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_used  (w_fifo_used),
    .o_data  (w_fifo_dout)
  );

`ifdef I2C_AMM_TIMEOUT_EN
  assign w_pop_rsp  = w_fifo_dout;
  assign rsp_data_o = DATA_W'(w_pop_rsp.data);
  assign rsp_err_o  = w_pop_rsp.err;
`else
  assign rsp_data_o = w_fifo_dout;
  assign rsp_err_o  = 1'b0;
`endif

  assign rsp_valid_o = !w_fifo_empty;
  assign busy_o      = (r_state != IDLE) || (r_outst != '0);

endmodule

// File: tb/tb_i2c_amm_master.sv
// Directed bench for i2c_amm_master with a hand-driven Avalon slave.
// Timeout scenario is included when I2C_AMM_TIMEOUT_EN is defined.
module tb_i2c_amm_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  avalon_mm_if #(.ADDR_W(5), .DATA_W(16)) u_amm ();

  i2c_amm_master #(
    .DATA_W    (16),
    .ADDR_W    (5),
    .MAX_OUTST (4),
    .RSP_DEPTH (8)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .amm_if      (u_amm)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one read with waitrequest low, then let it complete
  task automatic do_read(input logic [4:0] a);
    int k;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = a;
    #1;
    k = 0;
    while (!cmd_ready && k < 20) begin
      step();
      k++;
    end
    chk("rd_accept", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    step();
  endtask

  task automatic ret(input logic [15:0] d);
    u_amm.readdata      = d;
    u_amm.readdatavalid = 1'b1;
    step();
    u_amm.readdatavalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    u_amm.waitrequest   = 1'b0;
    u_amm.readdata      = '0;
    u_amm.readdatavalid = 1'b0;

    // Reset values
    step(); step();
    chk("rst_read",  32'(u_amm.read), 32'd0);
    chk("rst_write", 32'(u_amm.write), 32'd0);
    chk("rst_addr",  32'(u_amm.address), 32'd0);
    chk("rst_wdata", 32'(u_amm.writedata), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rspv",  32'(rsp_valid), 32'd0);
    chk("rst_err",   32'(rsp_err), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Single write, no wait states
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd3; cmd_wdata = 16'hA5A5;
    #1;
    chk("wr_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("wr_write", 32'(u_amm.write), 32'd1);
    chk("wr_addr",  32'(u_amm.address), 32'd3);
    chk("wr_data",  32'(u_amm.writedata), 32'hA5A5);
    chk("wr_read",  32'(u_amm.read), 32'd0);
    step();
    chk("wr_drop",  32'(u_amm.write), 32'd0);
    step();
    chk("wr_norsp", 32'(rsp_valid), 32'd0);
    chk("wr_idle",  32'(busy), 32'd0);

    // Read held by 3 waitrequest cycles, data two cycles after completion
    u_amm.waitrequest = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd7;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) u_amm.waitrequest = 1'b0;
      chk("rd_hold", 32'(u_amm.read), 32'd1);
      chk("rd_addr", 32'(u_amm.address), 32'd7);
      step();
    end
    chk("rd_drop", 32'(u_amm.read), 32'd0);
    chk("rd_busy", 32'(busy), 32'd1);
    step();
    u_amm.readdata = 16'h1234; u_amm.readdatavalid = 1'b1;
    #1;
    chk("rd_rspv_early", 32'(rsp_valid), 32'd0);
    step();
    u_amm.readdatavalid = 1'b0;
    chk("rd_rspv", 32'(rsp_valid), 32'd1);
    chk("rd_rspd", 32'(rsp_data), 32'h1234);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_pop", 32'(rsp_valid), 32'd0);
    chk("rd_idle", 32'(busy), 32'd0);

    // Five back-to-back reads against a limit of four outstanding
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd10;
    #1;
    chk("b2b_rdy0", 32'(cmd_ready), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_read", 32'(u_amm.read), 32'd1);
      chk("b2b_addr", 32'(u_amm.address), 32'(10 + i));
      cmd_addr = 5'(11 + i);
      #1;
      chk("b2b_rdy", 32'(cmd_ready), (i < 3) ? 32'd1 : 32'd0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk("b2b_stall_rd",  32'(u_amm.read), 32'd0);
      chk("b2b_stall_rdy", 32'(cmd_ready), 32'd0);
      step();
    end
    ret(16'h000A);
    chk("b2b_rdy_back", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("b2b_5th_read", 32'(u_amm.read), 32'd1);
    chk("b2b_5th_addr", 32'(u_amm.address), 32'd14);
    step();
    for (int i = 1; i < 5; i++) ret(16'(16'h000A + i));
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("b2b_rspv", 32'(rsp_valid), 32'd1);
      chk("b2b_order", 32'(rsp_data), 32'(16'h000A + i));
      step();
    end
    rsp_ready = 1'b0;
    chk("b2b_empty", 32'(rsp_valid), 32'd0);

    // Fill the response FIFO; reads blocked, writes still admitted
    for (int i = 0; i < 4; i++) do_read(5'(i));
    for (int i = 0; i < 4; i++) ret(16'(16'h0100 + i));
    for (int i = 4; i < 8; i++) do_read(5'(i));
    for (int i = 4; i < 8; i++) ret(16'(16'h0100 + i));
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd9;
    #1;
    chk("full_rd_rdy", 32'(cmd_ready), 32'd0);
    step();
    chk("full_rd_rdy2", 32'(cmd_ready), 32'd0);
    chk("full_no_read", 32'(u_amm.read), 32'd0);
    cmd_write = 1'b1; cmd_wdata = 16'h00C3; cmd_addr = 5'd1;
    #1;
    chk("full_wr_rdy", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("full_wr_issue", 32'(u_amm.write), 32'd1);
    chk("full_wr_data", 32'(u_amm.writedata), 32'h00C3);
    step();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("full_rspv", 32'(rsp_valid), 32'd1);
      chk("full_order", 32'(rsp_data), 32'(16'h0100 + i));
      step();
    end
    rsp_ready = 1'b0;
    chk("full_drained", 32'(rsp_valid), 32'd0);

    // Reset in the middle of a stalled read
    do_read(5'd2);
    ret(16'h0055);
    chk("mid_rspv", 32'(rsp_valid), 32'd1);
    u_amm.waitrequest = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd2;
    step();
    cmd_valid = 1'b0;
    chk("mid_read", 32'(u_amm.read), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(cmd_ready), 32'd0);
    step();
    chk("mid_read_drop", 32'(u_amm.read), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rspv_clr", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    u_amm.waitrequest = 1'b0;
    step();

    // Stray readdatavalid with nothing outstanding is ignored
    ret(16'hBEEF);
    step();
    chk("stray_rspv", 32'(rsp_valid), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);

`ifdef I2C_AMM_TIMEOUT_EN
    // Two reads never answered: HALT with two error responses
    begin : tmo_blk
      int k;
      do_read(5'd1);
      do_read(5'd2);
      k = 0;
      while (!rsp_valid && k < 400) begin
        step();
        k++;
      end
      chk("tmo_seen", 32'(rsp_valid), 32'd1);
      chk("tmo_err0", 32'(rsp_err), 32'd1);
      chk("tmo_data0", 32'(rsp_data), 32'd0);
      cmd_valid = 1'b1; cmd_write = 1'b1;
      #1;
      chk("tmo_rdy", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      chk("tmo_rspv1", 32'(rsp_valid), 32'd1);
      chk("tmo_err1", 32'(rsp_err), 32'd1);
      chk("tmo_data1", 32'(rsp_data), 32'd0);
      step();
      rsp_ready = 1'b0;
      chk("tmo_drained", 32'(rsp_valid), 32'd0);
      ret(16'h7777);
      step();
      chk("tmo_late_drop", 32'(rsp_valid), 32'd0);
      chk("tmo_halt_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("tmo_rst_busy", 32'(busy), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
